// File: rtl/el2_lsu_clkgate_ctl_if.sv
// Signal bundle between the LSU activity sources, the TLU quiesce handshake
// and the LSU clock-gate controller.
interface el2_lsu_clkgate_ctl_if;
  logic        clk_override;
  logic        dec_tlu_force_halt;
  logic        lsu_p_valid;
  logic        lsu_pkt_d_valid;
  logic        lsu_pkt_m_valid;
  logic        lsu_pkt_r_valid;
  logic        dma_dccm_req;
  logic        lsu_bus_buffer_empty_any;
  logic        lsu_stbuf_empty_any;
  logic        quiesce_req;
  logic        perf_clr;
  logic        lsu_free_clken;
  logic        quiesce_ack;
  logic        lsu_idle_any;
  logic [1:0]  lsu_cg_state;
  logic [15:0] lsu_gated_cnt;

  modport master (
    output clk_override, dec_tlu_force_halt, lsu_p_valid, lsu_pkt_d_valid,
           lsu_pkt_m_valid, lsu_pkt_r_valid, dma_dccm_req,
           lsu_bus_buffer_empty_any, lsu_stbuf_empty_any, quiesce_req, perf_clr,
    input  lsu_free_clken, quiesce_ack, lsu_idle_any, lsu_cg_state, lsu_gated_cnt
  );

  modport slave (
    input  clk_override, dec_tlu_force_halt, lsu_p_valid, lsu_pkt_d_valid,
           lsu_pkt_m_valid, lsu_pkt_r_valid, dma_dccm_req,
           lsu_bus_buffer_empty_any, lsu_stbuf_empty_any, quiesce_req, perf_clr,
    output lsu_free_clken, quiesce_ack, lsu_idle_any, lsu_cg_state, lsu_gated_cnt
  );
endinterface

// File: rtl/el2_lsu_clkgate_ctl.sv
// LSU free-clock enable sequencer with post-activity hysteresis, TLU quiesce
// handshake and a saturating gated-cycle counter.
module el2_lsu_clkgate_ctl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic                 clk,
  input  logic                 rst_l,
  el2_lsu_clkgate_ctl_if.slave lsu_cg
);

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    DRAIN    = 2'd1,
    IDLE     = 2'd2,
    QUIESCED = 2'd3
  } cg_state_e;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  cg_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             quiesce_ack_reg;
  logic [15:0]      gated_cnt_reg, gated_cnt_next;
  logic             busy;
  logic             clken;

  assign busy = lsu_cg.lsu_p_valid | lsu_cg.lsu_pkt_d_valid | lsu_cg.lsu_pkt_m_valid |
                lsu_cg.lsu_pkt_r_valid | lsu_cg.dma_dccm_req |
                ~lsu_cg.lsu_bus_buffer_empty_any | ~lsu_cg.lsu_stbuf_empty_any |
                lsu_cg.dec_tlu_force_halt;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ACTIVE: begin
        if (!busy) begin
          state_next = DRAIN;
          cnt_next   = CNT_LOAD;
        end
      end
      DRAIN: begin
        // Renewed activity wins over an expiring hold count.
        if (busy) begin
          state_next = ACTIVE;
        end else if (cnt_reg == '0) begin
          state_next = lsu_cg.quiesce_req ? QUIESCED : IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      IDLE: begin
        if (busy) begin
          state_next = ACTIVE;
        end else if (lsu_cg.quiesce_req) begin
          state_next = QUIESCED;
        end
      end
      QUIESCED: begin
        if (busy) begin
          state_next = ACTIVE;
        end else if (!lsu_cg.quiesce_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = DRAIN;
    endcase
  end

  // Busy is folded in combinationally so a wake from IDLE/QUIESCED clocks immediately.
  assign clken = lsu_cg.clk_override | lsu_cg.dec_tlu_force_halt |
                 (state_reg == ACTIVE) | (state_reg == DRAIN) |
                 (((state_reg == IDLE) | (state_reg == QUIESCED)) & busy);

  always_comb begin
    gated_cnt_next = gated_cnt_reg;
    if (lsu_cg.perf_clr) begin
      gated_cnt_next = '0;
    end else if (!clken && (gated_cnt_reg != 16'hFFFF)) begin
      gated_cnt_next = gated_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg       <= DRAIN;
      cnt_reg         <= CNT_LOAD;
      quiesce_ack_reg <= 1'b0;
      gated_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      quiesce_ack_reg <= (state_next == QUIESCED);
      gated_cnt_reg   <= gated_cnt_next;
    end
  end

  assign lsu_cg.lsu_free_clken = clken;
  assign lsu_cg.quiesce_ack    = quiesce_ack_reg;
  assign lsu_cg.lsu_idle_any   = (state_reg == IDLE) | (state_reg == QUIESCED);
  assign lsu_cg.lsu_cg_state   = state_reg;
  assign lsu_cg.lsu_gated_cnt  = gated_cnt_reg;

endmodule

// File: tb/tb_el2_lsu_clkgate_ctl.sv
// Scenario bench for the LSU clock-gate controller: expected per-cycle outputs
// are queued as stimulus is applied and compared at the mid-cycle sample point.
module tb_el2_lsu_clkgate_ctl;
  localparam logic [1:0] S_A = 2'd0, S_D = 2'd1, S_I = 2'd2, S_Q = 2'd3;
  localparam logic [3:0] NONE = 4'd0, PV = 4'd1, DMA = 4'd5, STB = 4'd7;

  typedef struct packed {
    logic       ovr;
    logic       clr;
    logic [3:0] sel;
    logic       q;
    logic       clken;
    logic       ack;
    logic [1:0] st;
  } row_t;

  typedef struct packed {
    logic        clken;
    logic        ack;
    logic        idle;
    logic [1:0]  st;
    logic [15:0] gcnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  el2_lsu_clkgate_ctl_if cg_if ();

  el2_lsu_clkgate_ctl #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_l  (rst_l),
    .lsu_cg (cg_if.slave)
  );

  obs_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_gcnt = 16'd0;

  function automatic row_t mk(input logic ovr, input logic clr, input logic [3:0] sel,
                              input logic q, input logic clken, input logic ack,
                              input logic [1:0] st);
    row_t r;
    r.ovr = ovr; r.clr = clr; r.sel = sel; r.q = q;
    r.clken = clken; r.ack = ack; r.st = st;
    return r;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.clken = cg_if.lsu_free_clken;
    o.ack   = cg_if.quiesce_ack;
    o.idle  = cg_if.lsu_idle_any;
    o.st    = cg_if.lsu_cg_state;
    o.gcnt  = cg_if.lsu_gated_cnt;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o.clken = 1'b1; o.ack = 1'b0; o.idle = 1'b0; o.st = S_D; o.gcnt = 16'd0;
    return o;
  endfunction

  task automatic drive_idle();
    cg_if.clk_override = 0; cg_if.perf_clr = 0; cg_if.dec_tlu_force_halt = 0;
    cg_if.lsu_p_valid = 0; cg_if.lsu_pkt_d_valid = 0; cg_if.lsu_pkt_m_valid = 0;
    cg_if.lsu_pkt_r_valid = 0; cg_if.dma_dccm_req = 0; cg_if.quiesce_req = 0;
    cg_if.lsu_bus_buffer_empty_any = 1; cg_if.lsu_stbuf_empty_any = 1;
  endtask

  // Drive one cycle of stimulus and queue what the outputs must show for it.
  task automatic apply_row(input row_t r);
    obs_t e;
    @(negedge clk);
    cg_if.clk_override             = r.ovr;
    cg_if.perf_clr                 = r.clr;
    cg_if.lsu_p_valid              = (r.sel == 4'd1);
    cg_if.lsu_pkt_d_valid          = (r.sel == 4'd2);
    cg_if.lsu_pkt_m_valid          = (r.sel == 4'd3);
    cg_if.lsu_pkt_r_valid          = (r.sel == 4'd4);
    cg_if.dma_dccm_req             = (r.sel == 4'd5);
    cg_if.lsu_bus_buffer_empty_any = (r.sel != 4'd6);
    cg_if.lsu_stbuf_empty_any      = (r.sel != 4'd7);
    cg_if.dec_tlu_force_halt       = (r.sel == 4'd8);
    cg_if.quiesce_req              = r.q;
    e.clken = r.clken; e.ack = r.ack; e.idle = r.st[1]; e.st = r.st; e.gcnt = exp_gcnt;
    sb.push_back(e);
    if (r.clr) exp_gcnt = 16'd0;
    else if (!r.clken && exp_gcnt != 16'hFFFF) exp_gcnt = exp_gcnt + 16'd1;
    #2;
  endtask

  task automatic test_reset();
    row_t rows[$];
    obs_t e, got;
    repeat (2) @(negedge clk);
    sb.push_back(reset_obs());
    e = sb.pop_front(); got = observe(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_hold got %h required %h", got, e);
    end
    @(posedge clk); #1 rst_l = 1'b1;
    exp_gcnt = 16'd0;
    repeat (4) rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_D));
    repeat (3) rows.push_back(mk(0, 0, NONE, 0, 0, 0, S_I));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      e = sb.pop_front(); got = observe(); n_checks++;
      $display("reset row %0d st=%0d clken=%b gcnt=%0d", i, got.st, got.clken, got.gcnt);
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_release[%0d] got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_wake_pulse();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(mk(0, 0, PV, 0, 1, 0, S_I));
    rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_A));
    repeat (4) rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_D));
    repeat (2) rows.push_back(mk(0, 0, NONE, 0, 0, 0, S_I));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      e = sb.pop_front(); got = observe(); n_checks++;
      $display("wake row %0d st=%0d clken=%b gcnt=%0d", i, got.st, got.clken, got.gcnt);
      if (got !== e) begin
        n_fail++;
        $display("FAIL wake_pulse[%0d] got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_drain_rebusy();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(mk(0, 0, PV, 0, 1, 0, S_I));
    rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_A));
    repeat (2) rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_D));
    rows.push_back(mk(0, 0, PV, 0, 1, 0, S_D));
    rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_A));
    repeat (4) rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_D));
    rows.push_back(mk(0, 0, NONE, 0, 0, 0, S_I));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      e = sb.pop_front(); got = observe(); n_checks++;
      $display("rebusy row %0d st=%0d clken=%b gcnt=%0d", i, got.st, got.clken, got.gcnt);
      if (got !== e) begin
        n_fail++;
        $display("FAIL drain_rebusy[%0d] got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_quiesce();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(mk(0, 0, STB, 1, 1, 0, S_I));
    repeat (5) rows.push_back(mk(0, 0, STB, 1, 1, 0, S_A));
    rows.push_back(mk(0, 0, NONE, 1, 1, 0, S_A));
    repeat (4) rows.push_back(mk(0, 0, NONE, 1, 1, 0, S_D));
    repeat (2) rows.push_back(mk(0, 0, NONE, 1, 0, 1, S_Q));
    rows.push_back(mk(0, 0, DMA, 1, 1, 1, S_Q));
    rows.push_back(mk(0, 0, NONE, 1, 1, 0, S_A));
    repeat (4) rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_D));
    rows.push_back(mk(0, 0, NONE, 0, 0, 0, S_I));
    rows.push_back(mk(0, 0, NONE, 1, 0, 0, S_I));
    rows.push_back(mk(0, 0, NONE, 1, 0, 1, S_Q));
    rows.push_back(mk(0, 0, NONE, 0, 0, 1, S_Q));
    rows.push_back(mk(0, 0, NONE, 0, 0, 0, S_I));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      e = sb.pop_front(); got = observe(); n_checks++;
      $display("quiesce row %0d st=%0d clken=%b ack=%b", i, got.st, got.clken, got.ack);
      if (got !== e) begin
        n_fail++;
        $display("FAIL quiesce[%0d] got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_busy_sources();
    row_t rows[$];
    obs_t e, got;
    for (int s = 1; s <= 8; s++) begin
      rows.push_back(mk(0, 0, 4'(s), 0, 1, 0, S_I));
      rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_A));
      repeat (4) rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_D));
      rows.push_back(mk(0, 0, NONE, 0, 0, 0, S_I));
    end
    foreach (rows[i]) begin
      apply_row(rows[i]);
      e = sb.pop_front(); got = observe(); n_checks++;
      $display("source row %0d sel=%0d st=%0d clken=%b", i, rows[i].sel, got.st, got.clken);
      if (got !== e) begin
        n_fail++;
        $display("FAIL busy_source[%0d] got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_override();
    row_t rows[$];
    obs_t e, got;
    repeat (3) rows.push_back(mk(1, 0, NONE, 0, 1, 0, S_I));
    repeat (2) rows.push_back(mk(0, 0, NONE, 0, 0, 0, S_I));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      e = sb.pop_front(); got = observe(); n_checks++;
      $display("override row %0d st=%0d clken=%b gcnt=%0d", i, got.st, got.clken, got.gcnt);
      if (got !== e) begin
        n_fail++;
        $display("FAIL override[%0d] got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_saturation();
    row_t rows[$];
    obs_t e, got;
    for (int c = 0; c < 65540; c++) begin
      apply_row(mk(0, 0, NONE, 0, 0, 0, S_I));
      void'(sb.pop_front());
    end
    repeat (2) rows.push_back(mk(0, 0, NONE, 0, 0, 0, S_I));
    rows.push_back(mk(0, 1, NONE, 0, 0, 0, S_I));
    repeat (2) rows.push_back(mk(0, 0, NONE, 0, 0, 0, S_I));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      e = sb.pop_front(); got = observe(); n_checks++;
      $display("saturate row %0d gcnt=%h", i, got.gcnt);
      if (got !== e) begin
        n_fail++;
        $display("FAIL saturation[%0d] got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    obs_t e, got;
    rows.push_back(mk(0, 0, NONE, 1, 0, 0, S_I));
    rows.push_back(mk(0, 0, NONE, 1, 0, 1, S_Q));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      e = sb.pop_front(); got = observe(); n_checks++;
      $display("areset row %0d st=%0d ack=%b", i, got.st, got.ack);
      if (got !== e) begin
        n_fail++;
        $display("FAIL async_setup[%0d] got %h required %h", i, got, e);
      end
    end
    // Drop reset between clock edges: outputs must change without a clock.
    rst_l = 1'b0;
    #1;
    sb.push_back(reset_obs());
    e = sb.pop_front(); got = observe(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL async_in_quiesced got %h required %h", got, e);
    end
    drive_idle();
    @(posedge clk); #1 rst_l = 1'b1;
    exp_gcnt = 16'd0;
    rows.delete();
    repeat (2) rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_D));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      e = sb.pop_front(); got = observe(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL async_drain[%0d] got %h required %h", i, got, e);
      end
    end
    rst_l = 1'b0;
    #1;
    sb.push_back(reset_obs());
    e = sb.pop_front(); got = observe(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL async_mid_drain got %h required %h", got, e);
    end
    @(posedge clk); #1 rst_l = 1'b1;
    exp_gcnt = 16'd0;
    rows.delete();
    repeat (4) rows.push_back(mk(0, 0, NONE, 0, 1, 0, S_D));
    rows.push_back(mk(0, 0, NONE, 0, 0, 0, S_I));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      e = sb.pop_front(); got = observe(); n_checks++;
      $display("redrain row %0d st=%0d clken=%b", i, got.st, got.clken);
      if (got !== e) begin
        n_fail++;
        $display("FAIL async_redrain[%0d] got %h required %h", i, got, e);
      end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_wake_pulse();
    test_drain_rebusy();
    test_quiesce();
    test_busy_sources();
    test_override();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
